osd_dem_uart_tx_sched: RTL and testbench
========================================

// Module: osd_dem_uart_tx_sched
// PURPOSE
// - Shares one debug-side character output stream between NUM_CH UART emulation channels.
// - Round-robin arbitration with burst hold, one registered output stage.
// - Stall-timeout and forced drop mode: a dead host never blocks any CPU-side UART.
// - Sits between the per-channel 16550 emulators and the single debug packetizer.
// PARAMETERS
// NUM_CH     4     number of requesting channels (>=2)
// MAX_BURST  16    max consecutive chars granted to one channel (>=1)
// TIMEOUT    1024  stall cycles before entering drop mode; 0 disables the timeout
// CNT_W      16    width of dropped-character counter
// PORTS
// clk        in   1          clock; all logic on rising edge
// rst        in   1          synchronous reset, active high
// in_valid   in   NUM_CH     per-channel char valid
// in_char    in   NUM_CH*8   per-channel char; channel i at [8*i+7:8*i]
// in_ready   out  NUM_CH     per-channel accept
// out_valid  out  1          output char valid (registered)
// out_char   out  8          output char (registered)
// out_chan   out  $clog2(NUM_CH)  source channel of out_char (registered)
// out_ready  in   1          downstream accept
// drop_force in   1          host absent: discard all input while high
// drop_active out 1          1 while in drop mode (timeout or forced)
// drop_cnt   out  CNT_W      chars discarded since reset, saturating
// BEHAVIOUR
// - Reset: out_valid=0, out_char=0, out_chan=0, drop_active=0, drop_cnt=0, rr pointer=0,
//   hold cleared, burst_cnt=0, stall_cnt=0; mode NORMAL. Reset mid-transfer discards the held char.
// - Modes: NORMAL, DROP. drop_active = (mode==DROP) | drop_force.
// - NORMAL, load slot: can_load = !out_valid | out_ready.
// - Selection: if hold set, in_valid[hold_idx]=1 and burst_cnt<MAX_BURST -> sel=hold_idx;
//   else sel = first valid channel scanning rr_ptr, rr_ptr+1, ... mod NUM_CH.
// - in_ready[sel]=can_load & in_valid[sel]; all others 0. At most one in_ready per cycle.
// - Transfer (in_valid&in_ready): next cycle out_valid=1, out_char/out_chan = sel data. Latency 1;
//   full throughput, back-to-back transfers each cycle when out_ready=1.
// - Burst: transfer from hold_idx while held -> burst_cnt++; else hold_idx=sel, burst_cnt=1, hold set.
//   burst_cnt reaching MAX_BURST -> hold cleared, rr_ptr=hold_idx+1 mod NUM_CH.
//   Held channel with in_valid=0 on a can_load cycle -> hold cleared, rr_ptr=hold_idx+1, and a
//   different valid channel may be selected that same cycle (no bubble).
// - out_valid & !out_ready: out_char/out_chan held stable. Output drops only via handshake or drop entry.
// - stall_cnt: ++ (saturating) each cycle out_valid & !out_ready; cleared otherwise.
// - Enter DROP when TIMEOUT!=0 and stall_cnt==TIMEOUT-1 with stall, or drop_force=1.
//   On entry: out_valid<=0 next cycle; held char discarded and counted in drop_cnt.
// - DROP: in_ready = all ones; every accepted char increments drop_cnt (saturates at all ones);
//   out_valid stays 0; hold cleared; rr_ptr unchanged.
// - Exit DROP (timeout-entered): first cycle drop_force=0 and out_ready=1 -> NORMAL next cycle,
//   stall_cnt=0. Forced-only DROP exits the cycle after drop_force falls.
// - Simultaneous: drop entry wins over a same-cycle input transfer (that char is dropped and counted).
// - drop_cnt counts only; never cleared except by rst.
// TESTING
// - Ch0 and ch2 valid constant, out_ready=1, MAX_BURST=4 -> out_chan 0,0,0,0,2,2,2,2,0...; one char/cycle.
// - Ch1 sends 2 chars then drops valid, ch3 valid -> out_chan 1,1,3 with no idle cycle between.
// - out_ready=0 for 5 cycles with out_valid=1 -> out_char/out_chan stable; all in_ready=0.
// - TIMEOUT=8, out_ready stuck 0 with ch0 streaming -> drop_active=1 after 8 stall cycles,
//   in_ready all 1, drop_cnt = discarded held char + accepted chars.
// - In DROP, raise out_ready 1 cycle -> NORMAL next cycle, first new char output with latency 1.
// - drop_force pulse 3 cycles, ch0 valid -> 3 chars counted; drop_cnt saturates at 0xFFFF in long run.

Source files
------------

// File: rtl/osd_dem_uart_tx_sched.sv
// osd_dem_uart_tx_sched: round-robin burst arbiter sharing one registered char stream among
// NUM_CH UART channels, with stall timeout and forced drop mode so a dead host never blocks a CPU.
module osd_dem_uart_tx_sched #(
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16,
  localparam int CW = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_valid_i,
  input  logic [NUM_CH*8-1:0] in_char_i,
  output logic [NUM_CH-1:0] in_ready_o,
  output logic              out_valid_o,
  output logic [7:0]        out_char_o,
  output logic [CW-1:0]     out_chan_o,
  input  logic              out_ready_i,
  input  logic              drop_force_i,
  output logic              drop_active_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int IW = $clog2(NUM_CH + 2);
  localparam logic [SW-1:0] TO_M1 = SW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic {NORMAL, DROP} mode_t;
  mode_t mode_q, mode_d;
  logic out_valid_q, out_valid_d, hold_q, hold_d;
  logic [7:0] out_char_q, out_char_d;
  logic [CW-1:0] out_chan_q, out_chan_d, rr_q, rr_d, hold_idx_q, hold_idx_d;
  logic [BW-1:0] burst_q, burst_d, burst_n;
  logic [SW-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic stall, timeout_hit, drop_now, can_load, hold_ok, hold_drop, scan_any, xfer;
  logic [CW-1:0] base, idx, scan_sel, sel;
  logic [NUM_CH-1:0] rdy;
  logic [IW-1:0] inc;
  logic [CNT_W+IW-1:0] sum;
  function automatic logic [CW-1:0] nxt(input logic [CW-1:0] x);
    return (x == CW'(NUM_CH - 1)) ? '0 : x + 1'b1;
  endfunction
  always_comb begin
    stall       = out_valid_q & !out_ready_i;
    timeout_hit = (TIMEOUT != 0) && (mode_q == NORMAL) && stall && (stall_q == TO_M1);
    drop_now    = (mode_q == DROP) | drop_force_i | timeout_hit;
    can_load    = !out_valid_q | out_ready_i;
    hold_ok     = hold_q & in_valid_i[hold_idx_q] & (burst_q < BW'(MAX_BURST));
    hold_drop   = hold_q & can_load & !in_valid_i[hold_idx_q];
    // a held channel that went idle hands the scan start to its successor in the same cycle
    base        = hold_drop ? nxt(hold_idx_q) : rr_q;
    scan_any    = 1'b0;
    scan_sel    = base;
    idx         = base;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CW'((int'(base) + k) % NUM_CH);
      if (in_valid_i[idx]) begin
        scan_any = 1'b1;
        scan_sel = idx;
      end
    end
    sel     = hold_ok ? hold_idx_q : scan_sel;
    xfer    = !drop_now & can_load & (hold_ok | scan_any);
    rdy     = drop_now ? '1 : (xfer ? NUM_CH'(1) << sel : '0);
    burst_n = hold_ok ? burst_q + 1'b1 : BW'(1);
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_chan_d  = out_chan_q;
    rr_d        = rr_q;
    hold_d      = hold_q;
    hold_idx_d  = hold_idx_q;
    burst_d     = burst_q;
    if (drop_now) begin
      hold_d      = 1'b0;
      burst_d     = '0;
      out_valid_d = 1'b0;
      if (mode_q == DROP && !drop_force_i && out_ready_i) mode_d = NORMAL;
      else if (timeout_hit) mode_d = DROP;
    end else begin
      if (hold_drop) begin
        hold_d  = 1'b0;
        burst_d = '0;
        rr_d    = nxt(hold_idx_q);
      end
      if (xfer) begin
        out_valid_d = 1'b1;
        out_char_d  = in_char_i[{sel, 3'b000} +: 8];
        out_chan_d  = sel;
        hold_idx_d  = sel;
        hold_d      = 1'b1;
        burst_d     = burst_n;
        if (burst_n == BW'(MAX_BURST)) begin
          hold_d = 1'b0;
          rr_d   = nxt(sel);
        end
      end else if (out_ready_i) out_valid_d = 1'b0;
    end
    stall_d = stall ? ((stall_q == '1) ? stall_q : stall_q + 1'b1) : '0;
    // discarded = stalled char lost on entry plus every char swallowed this cycle
    inc = '0;
    if (drop_now) begin
      inc = IW'(stall);
      for (int i = 0; i < NUM_CH; i++) inc = inc + IW'(in_valid_i[i] & rdy[i]);
    end
    sum        = {{IW{1'b0}}, drop_cnt_q} + (CNT_W + IW)'(inc);
    drop_cnt_d = (|sum[CNT_W +: IW]) ? '1 : sum[CNT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= NORMAL;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_chan_q  <= '0;
      rr_q        <= '0;
      hold_q      <= 1'b0;
      hold_idx_q  <= '0;
      burst_q     <= '0;
      stall_q     <= '0;
      drop_cnt_q  <= '0;
    end else begin
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_chan_q  <= out_chan_d;
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      hold_idx_q  <= hold_idx_d;
      burst_q     <= burst_d;
      stall_q     <= stall_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
  assign in_ready_o    = rdy;
  assign out_valid_o   = out_valid_q;
  assign out_char_o    = out_char_q;
  assign out_chan_o    = out_chan_q;
  assign drop_active_o = (mode_q == DROP) | drop_force_i;
  assign drop_cnt_o    = drop_cnt_q;
endmodule

// File: tb/tb_osd_dem_uart_tx_sched.sv
// tb_osd_dem_uart_tx_sched: directed scoreboard bench for the UART char scheduler.
module tb_osd_dem_uart_tx_sched;
  logic clk, rst;
  logic [3:0] in_valid, in_ready;
  logic [31:0] in_char;
  logic out_valid, out_ready, drop_force, drop_active;
  logic [7:0] out_char;
  logic [1:0] out_chan;
  logic [15:0] drop_cnt;
  logic [7:0] seq [4];
  logic [3:0] acc;
  logic [9:0] exp_q [$];
  logic [9:0] e;
  int checks, errors;

  osd_dem_uart_tx_sched #(.NUM_CH(4), .MAX_BURST(4), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_char_i(in_char), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_char_o(out_char), .out_chan_o(out_chan), .out_ready_i(out_ready),
    .drop_force_i(drop_force), .drop_active_o(drop_active), .drop_cnt_o(drop_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // channel i sends {i, running sequence number}
  always_comb for (int i = 0; i < 4; i++) in_char[8*i +: 8] = {2'(i), seq[i][5:0]};
  always @(negedge clk) acc <= in_valid & in_ready;
  always @(posedge clk)
    for (int i = 0; i < 4; i++) seq[i] <= rst ? 8'd0 : seq[i] + 8'(acc[i]);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int ch, input int c);
    exp_q.push_back({2'(ch), 8'(c)});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got chan %0d char %0h expected nothing", out_chan, out_char);
      end else begin
        e = exp_q.pop_front();
        if ({out_chan, out_char} != e) begin
          errors++;
          $display("FAIL sb_out: got chan %0d char %0h expected chan %0d char %0h",
                   out_chan, out_char, e[9:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = '0; out_ready = 1'b1; drop_force = 1'b0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_drop_active", drop_active, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    // burst of 4 from ch0, then 4 from ch2, then back to ch0
    step(1);
    push(0, 8'h00); push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
    push(2, 8'h80); push(2, 8'h81); push(2, 8'h82); push(2, 8'h83);
    push(0, 8'h04); push(0, 8'h05);
    in_valid = 4'b0101;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (k == 9) in_valid = '0;
      @(negedge clk);
      chk("t1_throughput", out_valid, 1);
    end
    // ch1 twice, then ch3 with no bubble
    step(1);
    push(1, 8'h40); push(1, 8'h41); push(3, 8'hC0);
    in_valid = 4'b1010;
    step(2);
    in_valid = 4'b1000;
    @(negedge clk);
    chk("t2_chan_a", out_chan, 1);
    step(1);
    in_valid = '0;
    @(negedge clk);
    chk("t2_no_bubble_valid", out_valid, 1);
    chk("t2_no_bubble_chan", out_chan, 3);
    // backpressure holds the output stable
    step(1);
    push(0, 8'h06);
    in_valid = 4'b0001;
    step(1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_valid", out_valid, 1);
      chk("t3_char", out_char, 8'h06);
      chk("t3_chan", out_chan, 0);
      chk("t3_in_ready", in_ready, 0);
    end
    step(1);
    out_ready = 1'b1;
    in_valid = '0;
    // timeout entry after 8 stall cycles
    step(1);
    in_valid = 4'b0001;
    out_ready = 1'b0;
    step(8);
    @(negedge clk);
    chk("t4_pre_active", drop_active, 0);
    chk("t4_pre_char", out_char, 8'h07);
    step(1);
    @(negedge clk);
    chk("t4_active", drop_active, 1);
    chk("t4_in_ready", in_ready, 4'hF);
    chk("t4_out_valid", out_valid, 0);
    chk("t4_cnt_entry", drop_cnt, 2);
    step(3);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_cnt_run", drop_cnt, 5);
    chk("t4_still_active", drop_active, 1);
    // exit on out_ready, then latency-1 output
    push(0, 8'h0D);
    step(1);
    out_ready = 1'b0;
    @(negedge clk);
    chk("t5_exit_active", drop_active, 0);
    chk("t5_exit_valid", out_valid, 0);
    chk("t5_exit_cnt", drop_cnt, 6);
    step(1);
    out_ready = 1'b1;
    in_valid = '0;
    @(negedge clk);
    chk("t5_first_valid", out_valid, 1);
    chk("t5_first_char", out_char, 8'h0D);
    // forced drop for 3 cycles
    step(1);
    in_valid = 4'b0001;
    drop_force = 1'b1;
    @(negedge clk);
    chk("t6_active", drop_active, 1);
    chk("t6_in_ready", in_ready, 4'hF);
    step(3);
    drop_force = 1'b0;
    in_valid = '0;
    @(negedge clk);
    chk("t6_released", drop_active, 0);
    chk("t6_cnt", drop_cnt, 9);
    chk("t6_out_valid", out_valid, 0);
    // forced entry while a char is stalled discards and counts it
    step(1);
    in_valid = 4'b0001;
    out_ready = 1'b0;
    step(1);
    in_valid = '0;
    drop_force = 1'b1;
    @(negedge clk);
    chk("t7_held_valid", out_valid, 1);
    step(1);
    drop_force = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t7_discard_valid", out_valid, 0);
    chk("t7_discard_cnt", drop_cnt, 10);
    // long forced run saturates the counter
    step(1);
    in_valid = 4'hF;
    drop_force = 1'b1;
    step(16400);
    drop_force = 1'b0;
    in_valid = '0;
    @(negedge clk);
    chk("t8_saturate", drop_cnt, 16'hFFFF);
    step(3);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
